// File: rtl/cic_pkg.sv
// Shared helpers for the CIC interpolator/decimator family: rate counter sizing
// and the arithmetic-shift / round-half-up / saturate output slice.
package cic_pkg;

    localparam int RMAX_DEFAULT = 640;
    localparam int SR_W         = 128;  // working width of sat_round; must cover CBITS

    function automatic int cnt_width(input int rmax);
        return (rmax > 1) ? $clog2(rmax) : 1;
    endfunction

    // y = sat(floor(acc / 2^sh) + acc[sh-1]) into an obits-wide signed range.
    function automatic logic signed [SR_W-1:0] sat_round(
        input logic signed [SR_W-1:0] acc,
        input logic [5:0]             sh,
        input int                     obits
    );
        logic signed [SR_W-1:0] t;
        logic signed [SR_W-1:0] hi;
        logic signed [SR_W-1:0] lo;
        t = acc >>> sh;
        if (sh != 6'd0 && acc[sh - 6'd1]) t = t + SR_W'(1);
        hi = (SR_W'(1) << (obits - 1)) - SR_W'(1);
        lo = ~hi;
        if (t > hi) t = hi;
        else if (t < lo) t = lo;
        return t;
    endfunction

endpackage

// File: rtl/cic_interp_var_if.sv
// I/Q sample stream between upstream FIR, the CIC interpolator and the DAC path.
interface cic_interp_var_if #(
    parameter int IBITS = 20,
    parameter int OBITS = 16
);
    logic             req;
    logic [IBITS-1:0] x_real;
    logic [IBITS-1:0] x_imag;
    logic [OBITS-1:0] y_real;
    logic [OBITS-1:0] y_imag;
    logic             y_valid;

    modport master (input req, y_real, y_imag, y_valid, output x_real, x_imag);
    modport slave  (output req, y_real, y_imag, y_valid, input x_real, x_imag);
endinterface

// File: rtl/cic_interp_lane.sv
// One real channel of the interpolating CIC: low-rate comb pipeline, zero stuffing,
// high-rate integrators and the registered round/saturate output slice.
module cic_interp_lane
    import cic_pkg::*;
#(
    parameter int STAGES = 5,
    parameter int IBITS  = 20,
    parameter int OBITS  = 16,
    parameter int CBITS  = 76
) (
    input  logic             clock,
    input  logic             flush,
    input  logic             en,
    input  logic             wrap,
    input  logic [5:0]       shift,
    input  logic [IBITS-1:0] x,
    output logic [OBITS-1:0] y
);

    // c[0] is the input register; c[STAGES] is the stuffed comb output and only
    // carries a sample for the single enable that follows a wrap.
    logic [STAGES:0][CBITS-1:0]   c;
    logic [STAGES-1:0][CBITS-1:0] d;
    logic [STAGES:1][CBITS-1:0]   acc;

    always_ff @(posedge clock) begin
        if (flush) begin
            c   <= '0;
            d   <= '0;
            acc <= '0;
            y   <= '0;
        end else if (en) begin
            if (wrap) begin
                c[0] <= {{(CBITS-IBITS){x[IBITS-1]}}, x};
                for (int k = 1; k <= STAGES; k++) begin
                    c[k]   <= c[k-1] - d[k-1];
                    d[k-1] <= c[k-1];
                end
            end else begin
                c[STAGES] <= '0;
            end
            // Modular accumulation: wrap-around is harmless given the growth bits.
            acc[1] <= acc[1] + c[STAGES];
            for (int k = 2; k <= STAGES; k++) acc[k] <= acc[k] + acc[k-1];
            y <= OBITS'(sat_round(SR_W'(signed'(acc[STAGES])), shift, OBITS));
        end
    end

endmodule

// File: rtl/cic_interp_var.sv
// Runtime-rate I/Q interpolating CIC: shared rate counter, req/valid strobes and
// configuration latch in front of two identical per-channel lanes.
module cic_interp_var
    import cic_pkg::*;
#(
    parameter int STAGES = 5,
    parameter int RMAX   = RMAX_DEFAULT,
    parameter int IBITS  = 20,
    parameter int OBITS  = 16,
    parameter int GBITS  = 56
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clock_en,
    input  logic [9:0]       rate,
    input  logic [5:0]       shift,
    input  logic             rate_load,
    cic_interp_var_if.slave  bus
);

    localparam int CBITS = IBITS + GBITS;
    localparam int CW    = cnt_width(RMAX);

    // The rate is held as R-1 so that R = RMAX fits even when RMAX is a power of two.
    logic [CW-1:0] cnt;
    logic [CW-1:0] r_m1;
    logic [CW-1:0] r_m1_nxt;
    logic [5:0]    shift_q;
    logic          req_q;
    logic          vld_q;
    logic          wrap;
    logic          flush;

    logic [1:0][IBITS-1:0] x_pk;
    logic [1:0][OBITS-1:0] y_pk;

    always_comb begin
        r_m1_nxt = '0;
        if (rate == 10'd0)          r_m1_nxt = '0;
        else if (int'(rate) > RMAX) r_m1_nxt = CW'(RMAX - 1);
        else                        r_m1_nxt = CW'(rate - 10'd1);
    end

    assign wrap  = (cnt == r_m1);
    assign flush = !reset_n || rate_load;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_m1    <= '0;
            shift_q <= '0;
            cnt     <= '0;
            req_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else if (rate_load) begin
            r_m1    <= r_m1_nxt;
            shift_q <= shift;
            cnt     <= '0;
            req_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else if (clock_en) begin
            cnt   <= wrap ? '0 : cnt + CW'(1);
            req_q <= wrap;
            vld_q <= 1'b1;
        end else begin
            req_q <= 1'b0;
            vld_q <= 1'b0;
        end
    end

    assign x_pk[0] = bus.x_real;
    assign x_pk[1] = bus.x_imag;

    for (genvar l = 0; l < 2; l++) begin : g_lane
        cic_interp_lane #(
            .STAGES (STAGES),
            .IBITS  (IBITS),
            .OBITS  (OBITS),
            .CBITS  (CBITS)
        ) u_lane (
            .clock (clock),
            .flush (flush),
            .en    (clock_en),
            .wrap  (wrap),
            .shift (shift_q),
            .x     (x_pk[l]),
            .y     (y_pk[l])
        );
    end

    assign bus.y_real  = y_pk[0];
    assign bus.y_imag  = y_pk[1];
    assign bus.req     = req_q;
    assign bus.y_valid = vld_q;

endmodule

// File: tb/tb_cic_interp_var.sv
// Self-checking bench: the reference is the CIC impulse response ((1-z^-R)/(1-z^-1))^N
// convolved with the captured samples, delayed by the documented latency.
module tb_cic_interp_var;

    localparam int N     = 5;
    localparam int RMAX  = 640;
    localparam int IBITS = 20;
    localparam int OBITS = 16;
    localparam int GBITS = 56;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       clock_en = 1'b0;
    logic       rate_load = 1'b0;
    logic [9:0] rate = '0;
    logic [5:0] shift = '0;

    cic_interp_var_if #(.IBITS(IBITS), .OBITS(OBITS)) bus ();

    cic_interp_var #(
        .STAGES(N), .RMAX(RMAX), .IBITS(IBITS), .OBITS(OBITS), .GBITS(GBITS)
    ) dut (
        .clock(clock), .reset_n(reset_n), .clock_en(clock_en), .rate(rate),
        .shift(shift), .rate_load(rate_load), .bus(bus.slave)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    int         m_r = 1, m_sh = 0, m_e = 0;
    longint     qr[$], qi[$];
    longint     h[];
    logic       exp_vld = 1'b0, exp_req = 1'b0;
    logic [OBITS-1:0] exp_r = '0, exp_i = '0;

    function automatic void build_h(input int r);
        longint cur[], nxt[];
        longint prev, add, sub;
        cur = new[1];
        cur[0] = 1;
        for (int s = 0; s < N; s++) begin
            nxt = new[cur.size() + r - 1];
            for (int n = 0; n < nxt.size(); n++) begin
                prev = (n > 0) ? nxt[n-1] : 0;
                add  = (n < cur.size()) ? cur[n] : 0;
                sub  = (n >= r && n - r < cur.size()) ? cur[n-r] : 0;
                nxt[n] = prev + add - sub;
            end
            cur = nxt;
        end
        h = cur;
    endfunction

    function automatic longint model_acc(input longint q[$]);
        longint a = 0;
        int n;
        for (int m = 0; m < q.size(); m++) begin
            if (q[m] != 0) begin
                n = m_e - (m_r - 1 + m * m_r) - (N * m_r + N + 1);
                if (n >= 0 && n < h.size()) a += q[m] * h[n];
            end
        end
        return a;
    endfunction

    function automatic int round_sat(input longint a, input int sh);
        longint d, n, q, lim;
        if (sh == 0) q = a;
        else begin
            d = longint'(1) << sh;
            n = a + d / 2;
            q = n / d;
            if ((n % d != 0) && (n < 0)) q = q - 1;
        end
        lim = longint'(1) << (OBITS - 1);
        if (q > lim - 1) q = lim - 1;
        if (q < -lim) q = -lim;
        return int'(q);
    endfunction

    function automatic logic [2*OBITS+1:0] obs();
        return {bus.y_valid, bus.req, bus.y_real, bus.y_imag};
    endfunction

    function automatic logic [2*OBITS+1:0] want();
        return {exp_vld, exp_req, exp_r, exp_i};
    endfunction

    task automatic model_flush(input int r, input int sh);
        m_r = r; m_sh = sh; m_e = 0;
        qr.delete(); qi.delete();
        build_h(r);
        exp_vld = 1'b0; exp_req = 1'b0; exp_r = '0; exp_i = '0;
    endtask

    task automatic do_reset(input bit with_load);
        reset_n = 1'b0; rate_load = with_load; rate = 10'd7; shift = 6'd5;
        clock_en = 1'($urandom_range(0, 1));
        @(posedge clock); #1;
        reset_n = 1'b1; rate_load = 1'b0;
        model_flush(1, 0);
    endtask

    task automatic do_load(input int r, input int sh);
        rate = r[9:0]; shift = sh[5:0]; rate_load = 1'b1;
        clock_en = 1'($urandom_range(0, 1));
        @(posedge clock); #1;
        rate_load = 1'b0;
        model_flush((r == 0) ? 1 : ((r > RMAX) ? RMAX : r), sh);
    endtask

    // Drives one cycle and advances the model; rate/shift wiggle to prove they are only sampled on load.
    task automatic tick(input bit en, input int xr, input int xi);
        bit wrap;
        clock_en = en;
        bus.x_real = xr[IBITS-1:0];
        bus.x_imag = xi[IBITS-1:0];
        rate = 10'($urandom); shift = 6'($urandom);
        if (en) begin
            wrap = (m_e % m_r) == m_r - 1;
            exp_r = OBITS'(round_sat(model_acc(qr), m_sh));
            exp_i = OBITS'(round_sat(model_acc(qi), m_sh));
            if (wrap) begin qr.push_back(longint'(xr)); qi.push_back(longint'(xi)); end
            exp_req = wrap; exp_vld = 1'b1;
            m_e++;
        end else begin
            exp_req = 1'b0; exp_vld = 1'b0;
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        do_reset(0);
        total++;
        if (obs() !== '0) begin bad++; $display("FAIL reset_state got=%h want=0", obs()); end
        for (int k = 0; k < 10; k++) begin
            tick(1, int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000);
            total++;
            if (obs() !== want()) begin bad++; $display("FAIL reset_run e=%0d got=%h want=%h", m_e, obs(), want()); end
        end
    endtask

    task automatic test_impulse();
        int first = -1;
        int seq[$];
        int gold[6] = '{1, 5, 10, 10, 5, 1};
        do_load(2, 0);
        for (int k = 0; k < 40; k++) begin
            tick(1, (m_e < 2) ? 1 : 0, 0);
            total++;
            if (obs() !== want()) begin bad++; $display("FAIL impulse e=%0d got=%h want=%h", m_e - 1, obs(), want()); end
            if (bus.y_real !== '0) begin
                if (first < 0) first = m_e - 1;
                seq.push_back(int'($signed(bus.y_real)));
            end
        end
        total++;
        if (first != 17) begin bad++; $display("FAIL impulse_latency got=%0d want=17", first); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (i >= seq.size() || seq[i] != gold[i]) begin
                bad++; $display("FAIL impulse_coef i=%0d got=%0d want=%0d", i, (i < seq.size()) ? seq[i] : 0, gold[i]);
            end
        end
    endtask

    task automatic test_dc(input bit gated);
        do_load(4, 8);
        for (int k = 0; k < (gated ? 300 : 100); k++) begin
            tick(gated ? (k % 3 == 0) : 1'b1, 1000, -1000);
            total++;
            if (obs() !== want()) begin bad++; $display("FAIL dc g=%0d k=%0d got=%h want=%h", gated, k, obs(), want()); end
        end
        total++;
        if (bus.y_real !== OBITS'(1000) || bus.y_imag !== OBITS'(-1000)) begin
            bad++; $display("FAIL dc_final g=%0d got=%0d/%0d want=1000/-1000", gated, $signed(bus.y_real), $signed(bus.y_imag));
        end
    endtask

    task automatic test_r1();
        int reqs = 0;
        do_load(0, 0);
        for (int k = 0; k < 30; k++) begin
            tick(1, 123, -77);
            reqs += int'(bus.req);
            total++;
            if (obs() !== want()) begin bad++; $display("FAIL r1 k=%0d got=%h want=%h", k, obs(), want()); end
        end
        total++;
        if (reqs != 30 || bus.y_real !== OBITS'(123)) begin
            bad++; $display("FAIL r1_final reqs=%0d y=%0d want reqs=30 y=123", reqs, $signed(bus.y_real));
        end
    endtask

    task automatic test_sat();
        do_load(16, 0);
        for (int k = 0; k < 140; k++) begin
            tick(1, (1 << (IBITS - 1)) - 1, -(1 << (IBITS - 1)));
            total++;
            if (obs() !== want()) begin bad++; $display("FAIL sat k=%0d got=%h want=%h", k, obs(), want()); end
        end
        total++;
        if (bus.y_real !== 16'h7fff || bus.y_imag !== 16'h8000) begin
            bad++; $display("FAIL sat_final got=%h/%h want=7fff/8000", bus.y_real, bus.y_imag);
        end
    endtask

    task automatic test_reconfig();
        int first = -1;
        int reqs = 0;
        do_load(4, 0);
        for (int k = 0; k < 30; k++) begin
            tick(1, int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000);
            total++;
            if (obs() !== want()) begin bad++; $display("FAIL reconf_a k=%0d got=%h want=%h", k, obs(), want()); end
        end
        do_load(8, 0);
        total++;
        if (obs() !== '0) begin bad++; $display("FAIL reconf_flush got=%h want=0", obs()); end
        for (int k = 0; k < 80; k++) begin
            tick(1, (m_e < 8) ? 1 : 0, 0);
            total++;
            if (obs() !== want()) begin bad++; $display("FAIL reconf_imp k=%0d got=%h want=%h", k, obs(), want()); end
            if (first < 0 && bus.y_real !== '0) first = m_e - 1;
        end
        total++;
        if (first != 53) begin bad++; $display("FAIL reconf_latency got=%0d want=53", first); end
        for (int k = 0; k < 20; k++) tick(1, 500, -500);
        do_reset(0);
        total++;
        if (obs() !== '0) begin bad++; $display("FAIL midreset got=%h want=0", obs()); end
        do_load(4, 0);
        for (int k = 0; k < 10; k++) tick(1, 700, 700);
        do_reset(1);
        for (int k = 0; k < 8; k++) begin
            tick(1, 9, 9);
            reqs += int'(bus.req);
            total++;
            if (obs() !== want()) begin bad++; $display("FAIL reset_load k=%0d got=%h want=%h", k, obs(), want()); end
        end
        total++;
        if (reqs != 8) begin bad++; $display("FAIL reset_load_rate reqs=%0d want=8", reqs); end
    endtask

    task automatic test_clamp();
        int reqs = 0;
        int pos = -1;
        do_load(1000, 0);
        for (int k = 0; k < 700; k++) begin
            tick(1, 0, 0);
            if (bus.req === 1'b1) begin reqs++; pos = k; end
            total++;
            if (obs() !== want()) begin bad++; $display("FAIL clamp k=%0d got=%h want=%h", k, obs(), want()); end
        end
        total++;
        if (reqs != 1 || pos != RMAX - 1) begin bad++; $display("FAIL clamp_wrap reqs=%0d pos=%0d want 1 at %0d", reqs, pos, RMAX - 1); end
    endtask

    task automatic test_random();
        int amp;
        for (int rnd = 0; rnd < 6; rnd++) begin
            amp = (rnd % 2 == 1) ? (1 << (IBITS - 1)) : (1 << 10);
            do_load(int'($urandom_range(1, 8)), int'($urandom_range(0, 10)));
            for (int k = 0; k < 120; k++) begin
                tick($urandom_range(0, 3) != 0,
                     int'($urandom_range(0, 2 * amp - 1)) - amp,
                     int'($urandom_range(0, 2 * amp - 1)) - amp);
                total++;
                if (obs() !== want()) begin
                    bad++; $display("FAIL random r=%0d sh=%0d k=%0d got=%h want=%h", m_r, m_sh, k, obs(), want());
                end
            end
        end
    endtask

    initial begin
        bus.x_real = '0;
        bus.x_imag = '0;
        #1;
        test_reset();
        test_impulse();
        test_dc(0);
        test_r1();
        test_sat();
        test_dc(1);
        test_reconfig();
        test_clamp();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cic_interp_var.md
Name: cic_interp_var

Overview:
- Runtime-programmable I/Q interpolating CIC (order STAGES) for the TX upsampling chain, between the polyphase FIR and the DAC-rate path.
- Generalises the fixed-rate order-5 interpolator:
  - parametrised order;
  - runtime rate 1..RMAX;
  - runtime output shift with round-half-up and saturation;
  - synchronous active-low reset;
  - flush-on-reconfigure;
  - output valid strobe.

Parameters:
STAGES  5    CIC order N (comb and integrator count), 1..8
RMAX    640  maximum interpolation rate; counter width is ceil(log2(RMAX))
IBITS   20   input sample width, two's complement
OBITS   16   output sample width, two's complement
GBITS   56   growth bits; must be at least (STAGES-1)*ceil(log2(RMAX))
CBITS   IBITS+GBITS  internal accumulator width (localparam)

Ports:
clock      in   1      system clock
reset_n    in   1      synchronous active-low reset
clock_en   in   1      one output sample per asserted cycle
rate       in   10     interpolation rate R; sampled only on rate_load
shift      in   6      output slice: y = sat(round(acc >>> shift))
rate_load  in   1      latch rate/shift, flush datapath
req        out  1      one-cycle strobe: next input sample consumed at next wrap
x_real     in   IBITS  input I
x_imag     in   IBITS  input Q
y_real     out  OBITS  output I (registered)
y_imag     out  OBITS  output Q (registered)
y_valid    out  1      high for one cycle when y_* updated

Behaviour:
- Reset (reset_n=0 at a clock edge): all comb, delay, integrator and output registers are 0; counter=0; req=0; y_valid=0. Latched rate = 1 and shift = 0.
- Reset has priority over everything. Reset mid-stream discards all state; no partial output is emitted.
- Rate clamping: rate_load latches R = clamp(rate, 1, RMAX), where 0 maps to 1. It also latches shift and performs a flush in the same cycle, identical to reset except the latched values. rate_load takes priority over clock_en.
- clock_en=0: all state holds; req=0; y_valid=0.
- clock_en=1, wrap cycle (counter==R-1):
  - counter←0;
  - input register ← sign-extended x_*;
  - req←1;
  - comb chain advances one stage: c_k ← c_{k-1} − d_{k-1}, d_{k-1} ← c_{k-1}. The chain is pipelined, one register per stage.
- clock_en=1, non-wrap cycle: counter+1; comb output c_N forced to 0 (zero stuffing); req←0.
- R=1: every enable is a wrap, so there is no zero stuffing.
- Integrators: on every clock_en, i_1←i_1+c_N and i_k←i_k+i_{k-1}, all in CBITS with wrap-around (modular) arithmetic, as CIC requires.
- Output stage, on clock_en:
  - t = (i_N >>> shift) + i_N[shift-1], with the rounding bit = 0 when shift=0;
  - saturate t to [−2^(OBITS-1), 2^(OBITS-1)−1];
  - register into y_*; y_valid←1.
- Latency: sample captured on wrap enable e0 gives first non-zero y on enable e0 + N·R + N + 1.
- DC gain before shift is R^(N-1).
- Upstream handshake: on seeing req, upstream must present the next sample before the next wrap enable. A held sample is re-used, with no error flag.
- Simultaneous rate_load and reset_n=0: reset wins, so R=1 and shift=0.

Decomposition:
- Package cic_pkg:
  - RMAX_DEFAULT;
  - counter-width function (clog2);
  - sat_round function (arith shift, round-half-up, saturate; shared with the decimator).
- Sub-module cic_interp_lane: one real channel (comb chain, zero stuffing, integrators, round/sat), instantiated twice.
- Counter, req and y_valid logic stays in the top.

Test Plan:
1. Impulse, N=5, R=2, shift=0: x_real=1 for one sample, then 0 → y_real sequence 1,5,10,10,5,1 (interleaved per upsampling), then zeros. Starts at enable e0+N·R+N+1 = e0+16.
2. DC, N=5, R=4, shift=8: x_real=1000, x_imag=−1000 constant → after settling y_real=1000, y_imag=−1000. req pulses every 4th enable.
3. R=1 (rate=0 loaded → clamps to 1), shift=0: DC 123 → y=123. req high on every enable.
4. Saturation, N=5, R=16, shift=0: x=+2^(IBITS-1)−1 → y_real=32767; negative full-scale → −32768. No wrap in the output.
5. clock_en gated 1-of-3 during test 2 → identical y sequence. y_valid only on enable cycles; state frozen otherwise.
6. rate_load mid-stream from R=4 to R=8, and reset_n low mid-stream → next output 0, counter restarts. Impulse latency recomputed with the new R. rate_load with reset_n=0 yields R=1.
